div_ctrl: RTL
=============

Name: div_ctrl

Overview:
Sequencing controller for the 32-bit restoring divider. It drives the Remainder register's write, shift, quotient-bit and final-adjust controls, plus the divisor register load and ALU subtract enable. It runs one division per start request and reports completion and divide-by-zero. It sits between the ALU top-level decode and the divider datapath (Remainder register, divisor register, ALU).

Parameters:
N, 32, operand width = iteration count; the counter width is clog2(N)+1.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
start  input  1  request a division; sampled only in IDLE
divisor_zero  input  1  divisor operand == 0, sampled with start
alu_neg  input  1  sign of (Remainder upper half − divisor) from the ALU, combinational
busy  output  1  high from the accepting edge until DONE is exited
done  output  1  one-cycle completion pulse
dz_err  output  1  divide-by-zero flag, held until the next accepted start
div_wrctrl  output  1  load divisor register
wrctrl  output  1  load Remainder with {N'b0, dividend}
alu_sub  output  1  ALU in subtract mode
rem_wr_hi  output  1  write ALU difference into the Remainder upper half
rem_shift  output  1  shift Remainder left by 1
ozctrl  output  1  bit inserted at the Remainder LSB on a shift
ready_wait  output  1  final-adjust prepare (Remainder control)
ready  output  1  final upper-half shift-right (Remainder control)

Behaviour:
- Reset (rst=0, async): state=IDLE, counter=0, q_bit=0. All outputs 0, including dz_err.
- All outputs decode from registered state. The only exception is rem_wr_hi, which is Mealy: rem_wr_hi = (state==SUB) & ~alu_neg.
- IDLE: outputs 0.
  - start=1 & divisor_zero=1 -> DONE with dz_err set; no datapath control is pulsed.
  - start=1 & divisor_zero=0 -> LOAD; dz_err cleared.
- LOAD (1 cycle): div_wrctrl=1, wrctrl=1. Next state: INIT.
- INIT (1 cycle): rem_shift=1, ozctrl=0. Counter cleared to 0. Next state: SUB.
- SUB (1 cycle): alu_sub=1. rem_wr_hi as above. q_bit <= ~alu_neg. Next state: SHIFT.
- SHIFT (1 cycle): rem_shift=1, ozctrl=q_bit. Counter += 1.
  - If counter (pre-increment) == N-1 -> WAIT; else -> SUB.
- WAIT (1 cycle): ready_wait=1. Next state: READY.
- READY (1 cycle): ready_wait=1, ready=1. Next state: DONE.
- DONE (1 cycle): done=1. Next state: IDLE.
- busy=1 in every state except IDLE. busy is 0 in the cycle after DONE.
- Latency, with the accepting edge as edge 0: done is high between edges 2N+4 and 2N+5 (edges 68–69 for N=32). The divide-by-zero path gives done between edges 1 and 2.
- Exactly N SUB and N SHIFT cycles per division; exactly one each of div_wrctrl, wrctrl, ready and done.
- start while busy is ignored (no queueing).
- start held high continuously: a new division is accepted on the edge where state==IDLE, i.e. back-to-back with a one-cycle IDLE gap.
- alu_neg is don't-care outside SUB; X on alu_neg outside SUB must not propagate to outputs.
- Reset mid-operation aborts immediately to IDLE. Datapath contents are undefined afterward; the next start fully reloads.
- Counter never wraps: it only counts within SUB/SHIFT and is cleared in INIT.
- Illegal or unused state encodings -> IDLE on the next edge.

Test Plan:
Bench instantiates div_ctrl with Remainder, a divisor register and a behavioural ALU; clk period 10 ns.
- Reset then dividend=100, divisor=7, start one cycle -> done at edge 68 after accept; quotient=14, remainder=2; exactly 32 SUB/SHIFT pairs counted.
- dividend=12, divisor=4 -> quotient=3, remainder=0; dz_err=0. Then dividend=0xFFFFFFFF, divisor=1 -> quotient=0xFFFFFFFF, remainder=0.
- divisor=0, start -> done at edge 1, dz_err=1, div_wrctrl/wrctrl never asserted. A following start with divisor=3, dividend=10 -> dz_err cleared at accept; quotient=3, remainder=1.
- Pulse start at edges 5, 20 and 60 during a busy division -> ignored; only one done; result unchanged.
- rst low at iteration 10 (mid-SUB) -> all outputs 0 asynchronously, state IDLE. rst high, then start 50/6 -> quotient=8, remainder=2.
- start held high for 200 cycles with 9/2 -> done at edges 68 and 138 (one-cycle IDLE gap); each result quotient=4, remainder=1.

Source files
------------

// File: rtl/div_ctrl.sv
// div_ctrl: sequencing controller for the N-bit restoring divider.
// Controls are registered from the next-state decode; only rem_wr_hi follows alu_neg directly.
module div_ctrl #(
  parameter int N = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic divisor_zero,
  input  logic alu_neg,
  output logic busy,
  output logic done,
  output logic dz_err,
  output logic div_wrctrl,
  output logic wrctrl,
  output logic alu_sub,
  output logic rem_wr_hi,
  output logic rem_shift,
  output logic ozctrl,
  output logic ready_wait,
  output logic ready
);

  localparam int CW = $clog2(N) + 1;

  localparam logic [3:0] IDLE  = 4'd0;
  localparam logic [3:0] LOAD  = 4'd1;
  localparam logic [3:0] INIT  = 4'd2;
  localparam logic [3:0] SUB   = 4'd3;
  localparam logic [3:0] SHIFT = 4'd4;
  localparam logic [3:0] WAIT  = 4'd5;
  localparam logic [3:0] READY = 4'd6;
  localparam logic [3:0] DONE  = 4'd7;

  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

  logic [3:0]    state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          q_bit_r, q_bit_s;
  logic          dz_err_r, dz_err_s;

  logic busy_r, busy_s;
  logic done_r, done_s;
  logic div_wrctrl_r, div_wrctrl_s;
  logic wrctrl_r, wrctrl_s;
  logic alu_sub_r, alu_sub_s;
  logic rem_shift_r, rem_shift_s;
  logic ozctrl_r, ozctrl_s;
  logic ready_wait_r, ready_wait_s;
  logic ready_r, ready_s;

  // Next-state, iteration counter, quotient bit and divide-by-zero flag.
  always_comb begin
    state_s  = IDLE;
    cnt_s    = cnt_r;
    q_bit_s  = q_bit_r;
    dz_err_s = dz_err_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (divisor_zero) begin
            state_s  = DONE;
            dz_err_s = 1'b1;
          end else begin
            state_s  = LOAD;
            dz_err_s = 1'b0;
          end
        end else begin
          state_s = IDLE;
        end
      end
      LOAD:  state_s = INIT;
      INIT: begin
        cnt_s   = CNT_ZERO;
        state_s = SUB;
      end
      SUB: begin
        // alu_neg is only looked at here, so an undriven ALU elsewhere stays harmless.
        q_bit_s = ~alu_neg;
        state_s = SHIFT;
      end
      SHIFT: begin
        cnt_s = cnt_r + CNT_ONE;
        if (cnt_r == LAST_ITER) begin
          state_s = WAIT;
        end else begin
          state_s = SUB;
        end
      end
      WAIT:    state_s = READY;
      READY:   state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Control decode of the state about to be entered, so the output flops match the state flops.
  always_comb begin
    busy_s       = (state_s != IDLE);
    done_s       = (state_s == DONE);
    div_wrctrl_s = (state_s == LOAD);
    wrctrl_s     = (state_s == LOAD);
    alu_sub_s    = (state_s == SUB);
    rem_shift_s  = (state_s == INIT) || (state_s == SHIFT);
    ozctrl_s     = (state_s == SHIFT) && q_bit_s;
    ready_wait_s = (state_s == WAIT) || (state_s == READY);
    ready_s      = (state_s == READY);
  end

  // State and control registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      cnt_r        <= CNT_ZERO;
      q_bit_r      <= 1'b0;
      dz_err_r     <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      div_wrctrl_r <= 1'b0;
      wrctrl_r     <= 1'b0;
      alu_sub_r    <= 1'b0;
      rem_shift_r  <= 1'b0;
      ozctrl_r     <= 1'b0;
      ready_wait_r <= 1'b0;
      ready_r      <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      q_bit_r      <= q_bit_s;
      dz_err_r     <= dz_err_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      div_wrctrl_r <= div_wrctrl_s;
      wrctrl_r     <= wrctrl_s;
      alu_sub_r    <= alu_sub_s;
      rem_shift_r  <= rem_shift_s;
      ozctrl_r     <= ozctrl_s;
      ready_wait_r <= ready_wait_s;
      ready_r      <= ready_s;
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign dz_err     = dz_err_r;
  assign div_wrctrl = div_wrctrl_r;
  assign wrctrl     = wrctrl_r;
  assign alu_sub    = alu_sub_r;
  assign rem_shift  = rem_shift_r;
  assign ozctrl     = ozctrl_r;
  assign ready_wait = ready_wait_r;
  assign ready      = ready_r;
  assign rem_wr_hi  = alu_sub_r & ~alu_neg;

endmodule
